// File: rtl/prog_loader.sv
// Boot loader: copies an hps_io ioctl download into program RAM while holding the CPU in reset.
// Optional build macro PROG_LOADER_CKSUM_EN adds a 16-bit sum of every byte committed to RAM.
module prog_loader #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned LOAD_INDEX  = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    output logic              cpu_reset_n,
    output logic              copy_in_progress,
    output logic [ADDR_W:0]   byte_count,
`ifdef PROG_LOADER_CKSUM_EN
    output logic [15:0]       cksum,
`endif
    output logic              overflow
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BC_W  = ADDR_W + 1;
    localparam int unsigned IOA_W = 27;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t state, state_next;

    logic              dl_q;
    logic [CNT_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_din;
    logic              ld_we;

    logic              dl_rise_c;
    logic              dl_fall_c;
    logic              load_start_c;
    logic              hold_done_c;
    logic              in_range_c;
    logic              ld_wr_c;
    logic              ld_commit_c;
    logic              cpu_pass_c;
    logic [BC_W-1:0]   wr_end_c;

    // Edge detection uses the registered download flag against the live input.
    assign dl_rise_c    = ioctl_download & ~dl_q;
    assign dl_fall_c    = ~ioctl_download & dl_q;
    assign load_start_c = dl_rise_c && (ioctl_index == 8'(LOAD_INDEX));
    assign hold_done_c  = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign in_range_c   = (ioctl_addr[IOA_W-1:ADDR_W] == '0);
    assign ld_wr_c      = (state == ST_LOAD) && ioctl_wr;
    assign ld_commit_c  = ld_wr_c && in_range_c;
    assign wr_end_c     = BC_W'(ioctl_addr[ADDR_W-1:0]) + BC_W'(1);

    // The CPU owns the RAM port only in RUN, and loses it the cycle a load starts.
    assign cpu_pass_c       = (state == ST_RUN) && !load_start_c;
    assign mem_addr         = cpu_pass_c ? cpu_addr : ld_addr;
    assign mem_we           = cpu_pass_c ? cpu_we   : ld_we;
    assign mem_din          = cpu_pass_c ? cpu_dout : ld_din;
    assign cpu_reset_n      = (state == ST_RUN);
    assign copy_in_progress = (state == ST_LOAD);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_HOLD: if (hold_done_c) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            ST_LOAD: if (dl_fall_c) state_next = ST_HOLD;
            default: state_next = ST_HOLD;
        endcase
        if (load_start_c) begin
            state_next = ST_LOAD;
        end
    end

    // Hold counter runs only while staying in HOLD; any other path clears it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state == ST_HOLD && state_next == ST_HOLD) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            ld_we      <= 1'b0;
            ld_addr    <= '0;
            ld_din     <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            ld_we <= ld_commit_c;
            if (ld_commit_c) begin
                ld_addr <= ioctl_addr[ADDR_W-1:0];
                ld_din  <= ioctl_dout;
            end
            if (load_start_c) begin
                byte_count <= '0;
                overflow   <= 1'b0;
            end else if (ld_wr_c) begin
                if (!in_range_c) begin
                    overflow <= 1'b1;
                end else if (wr_end_c > byte_count) begin
                    byte_count <= wr_end_c;
                end
            end
        end
    end

`ifdef PROG_LOADER_CKSUM_EN
    // Sum updates on the same edge that raises the matching RAM write strobe.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (load_start_c) begin
            cksum <= '0;
        end else if (ld_commit_c) begin
            cksum <= cksum + 16'(ioctl_dout);
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed/random bench for prog_loader against a RAM model and a byte-level expectation model.
module tb_prog_loader;

    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned HOLD_CYCLES = 256;
    localparam int unsigned LOAD_INDEX  = 1;
    localparam int unsigned DEPTH       = 1 << ADDR_W;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [26:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [7:0]        cpu_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_din;
    logic              cpu_reset_n;
    logic              copy_in_progress;
    logic [ADDR_W:0]   byte_count;
    logic              overflow;
`ifdef PROG_LOADER_CKSUM_EN
    logic [15:0]       cksum;
`endif

    prog_loader #(
        .ADDR_W     (ADDR_W),
        .HOLD_CYCLES(HOLD_CYCLES),
        .LOAD_INDEX (LOAD_INDEX)
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_index     (ioctl_index),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .cpu_addr        (cpu_addr),
        .cpu_we          (cpu_we),
        .cpu_dout        (cpu_dout),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_din         (mem_din),
        .cpu_reset_n     (cpu_reset_n),
        .copy_in_progress(copy_in_progress),
        .byte_count      (byte_count),
`ifdef PROG_LOADER_CKSUM_EN
        .cksum           (cksum),
`endif
        .overflow        (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Program RAM attached to the mem_* port.
    logic [7:0] ram [DEPTH];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
    end

    // Expectation model: what RAM should hold and what the status outputs should read.
    logic [7:0]  exp_ram   [DEPTH];
    bit          exp_valid [DEPTH];
    int unsigned exp_bc;
    bit          exp_ov;
    logic [15:0] exp_ck;
    logic [26:0] dl_addr [64];
    logic [7:0]  dl_data [64];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_write(input int unsigned a, input logic [7:0] d);
        exp_ram[a]   = d;
        exp_valid[a] = 1'b1;
    endtask

    // Count clock edges until the CPU leaves reset; a missing release shows up as a wrong count.
    task automatic wait_release(input string tag, input int exp_edges);
        int n = 0;
        while (n < exp_edges + 50) begin
            @(posedge clk_sys); #1;
            n++;
            if (cpu_reset_n === 1'b1) break;
        end
        check(tag, 32'(n), 32'(exp_edges));
    endtask

    task automatic passthrough(input int iters);
        for (int i = 0; i < iters; i++) begin
            @(negedge clk_sys);
            cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_dout = 8'($urandom);
            cpu_we   = 1'($urandom);
            #1;
            check("pass_addr", 32'(mem_addr), 32'(cpu_addr));
            check("pass_we",   32'(mem_we),   32'(cpu_we));
            check("pass_din",  32'(mem_din),  32'(cpu_dout));
            if (cpu_we) model_write(int'(cpu_addr), cpu_dout);
        end
        @(negedge clk_sys);
        cpu_we = 1'b0;
    endtask

    // Non-matching downloads are only issued from RUN, with CPU writes running alongside.
    task automatic download(input logic [7:0] idx, input int n, input bit coinc);
        bit match = (idx == 8'(LOAD_INDEX));
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (match) begin
            cpu_we   = 1'b1;
            cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            check("cpu_blocked", 32'(mem_we), 32'(0));
            cpu_we = 1'b0;
        end
        @(posedge clk_sys); #1;
        if (match) begin
            exp_bc = 0;
            exp_ov = 1'b0;
            exp_ck = '0;
            check("entry_copy",  32'(copy_in_progress), 32'(1));
            check("entry_rst",   32'(cpu_reset_n),      32'(0));
            check("entry_bc",    32'(byte_count),       32'(0));
            check("entry_ov",    32'(overflow),         32'(0));
        end
        for (int i = 0; i < n; i++) begin
            bit inr;
            bit commit;
            bit last;
            bit exp_we;
            int gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk_sys); #1;
                check("idle_we", 32'(mem_we), 32'(0));
            end
            @(negedge clk_sys);
            last       = (i == n - 1);
            ioctl_wr   = 1'b1;
            ioctl_addr = dl_addr[i];
            ioctl_dout = dl_data[i];
            if (last && coinc) ioctl_download = 1'b0;
            inr    = (dl_addr[i] < 27'(DEPTH));
            commit = match && inr;
            exp_we = commit;
            if (commit) begin
                model_write(int'(dl_addr[i]), dl_data[i]);
                if (int'(dl_addr[i]) + 1 > int'(exp_bc)) exp_bc = int'(dl_addr[i]) + 1;
                exp_ck = exp_ck + 16'(dl_data[i]);
            end
            if (match && !inr) exp_ov = 1'b1;
            if (!match) begin
                cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                cpu_dout = 8'($urandom);
                cpu_we   = 1'b1;
                exp_we   = 1'b1;
                model_write(int'(cpu_addr), cpu_dout);
            end
            @(posedge clk_sys); #1;
            check("wr_we", 32'(mem_we), 32'(exp_we));
            if (commit) begin
                check("wr_addr", 32'(mem_addr), 32'(dl_addr[i][ADDR_W-1:0]));
                check("wr_din",  32'(mem_din),  32'(dl_data[i]));
            end
            if (!match) begin
                check("nm_addr", 32'(mem_addr), 32'(cpu_addr));
                check("nm_rst",  32'(cpu_reset_n), 32'(1));
            end else begin
                check("load_bc", 32'(byte_count), 32'(exp_bc));
                check("load_ov", 32'(overflow),   32'(exp_ov));
`ifdef PROG_LOADER_CKSUM_EN
                check("load_ck", 32'(cksum), 32'(exp_ck));
`endif
                if (!(last && coinc)) check("load_copy", 32'(copy_in_progress), 32'(1));
            end
            ioctl_wr = 1'b0;
            cpu_we   = 1'b0;
        end
        if (!coinc) begin
            @(negedge clk_sys);
            ioctl_download = 1'b0;
            @(posedge clk_sys); #1;
        end
        if (match) begin
            check("exit_copy", 32'(copy_in_progress), 32'(0));
            check("exit_rst",  32'(cpu_reset_n),      32'(0));
            check("exit_bc",   32'(byte_count),       32'(exp_bc));
            check("exit_ov",   32'(overflow),         32'(exp_ov));
        end else begin
            check("nm_exit_rst", 32'(cpu_reset_n), 32'(1));
        end
    endtask

    initial begin
        int bad;
        int nvalid;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_addr       = '0;
        cpu_we         = 1'b0;
        cpu_dout       = '0;
        exp_bc         = 0;
        exp_ov         = 1'b0;
        exp_ck         = '0;
        for (int a = 0; a < int'(DEPTH); a++) exp_valid[a] = 1'b0;

        #1;
        check("rst_cpu_reset_n", 32'(cpu_reset_n),      32'(0));
        check("rst_copy",        32'(copy_in_progress), 32'(0));
        check("rst_bc",          32'(byte_count),       32'(0));
        check("rst_ov",          32'(overflow),         32'(0));
        check("rst_we",          32'(mem_we),           32'(0));
        check("rst_addr",        32'(mem_addr),         32'(0));
        check("rst_din",         32'(mem_din),          32'(0));

        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        wait_release("poweron_hold", HOLD_CYCLES);
        passthrough(6);

        dl_addr[0] = 27'd0; dl_data[0] = 8'h3E;
        dl_addr[1] = 27'd1; dl_data[1] = 8'h41;
        dl_addr[2] = 27'd2; dl_data[2] = 8'hD3;
        dl_addr[3] = 27'd3; dl_data[3] = 8'h00;
        download(8'd1, 4, 1'b0);
        check("plan_bc", 32'(byte_count), 32'(4));
`ifdef PROG_LOADER_CKSUM_EN
        check("plan_ck", 32'(cksum), 32'h0152);
`endif
        wait_release("plan_hold", HOLD_CYCLES);

        dl_addr[0] = 27'h0000005; dl_data[0] = 8'h77;
        dl_addr[1] = 27'h0001000; dl_data[1] = 8'hAA;
        dl_addr[2] = 27'h4000000; dl_data[2] = 8'hBB;
        dl_addr[3] = 27'h0000003; dl_data[3] = 8'h55;
        download(8'd1, 4, 1'b0);
        wait_release("ovf_hold", HOLD_CYCLES);

        for (int i = 0; i < 4; i++) begin
            dl_addr[i] = 27'(i);
            dl_data[i] = 8'($urandom);
        end
        download(8'd2, 4, 1'b0);
        passthrough(4);

        for (int i = 0; i < 16; i++) begin
            dl_addr[i] = 27'($urandom_range(0, DEPTH - 1));
            dl_data[i] = 8'($urandom);
        end
        dl_addr[9] = dl_addr[2];
        download(8'd1, 16, 1'b1);
        repeat (40) @(posedge clk_sys);
        #1;
        check("midhold_rst", 32'(cpu_reset_n), 32'(0));
        for (int i = 0; i < 3; i++) begin
            dl_addr[i] = 27'($urandom_range(0, DEPTH - 1));
            dl_data[i] = 8'($urandom);
        end
        download(8'd1, 3, 1'b0);
        wait_release("restart_hold", HOLD_CYCLES);
`ifdef PROG_LOADER_CKSUM_EN
        check("ck_stable", 32'(cksum), 32'(exp_ck));
`endif
        check("bc_stable", 32'(byte_count), 32'(exp_bc));

        bad    = 0;
        nvalid = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (exp_valid[a]) begin
                nvalid++;
                if (ram[a] !== exp_ram[a]) bad++;
            end
        end
        check("ram_contents", 32'(bad), 32'(0));
        check("ram_addr0", 32'(ram[0]), 32'h3E);

        // Reset while a loader write strobe is on the RAM port.
        @(negedge clk_sys);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'd7;
        ioctl_dout = 8'h5A;
        @(posedge clk_sys); #1;
        check("pre_rst_we", 32'(mem_we), 32'(1));
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("async_rst_cpu",  32'(cpu_reset_n),      32'(0));
        check("async_rst_copy", 32'(copy_in_progress), 32'(0));
        check("async_rst_we",   32'(mem_we),           32'(0));
        check("async_rst_bc",   32'(byte_count),       32'(0));
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        wait_release("rerun_hold", HOLD_CYCLES);
        passthrough(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
